fetch_queue_unit: RTL and testbench

- Parametrised successor to the single-PC fetch stage.
- Owns the PC and issues in-order word fetches to a variable-latency instruction memory. Buffers returned instructions with their PC, PC+4 and PC+8 in a QDEPTH-entry queue.
- Hands entries to decode with a valid/ready handshake. Branch/jump redirects flush the queue and discard in-flight responses.
- Sits between the redirect logic (NPC/branch resolve in ID/EX) and the IF/ID boundary.

---
 rtl/fetch_queue_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_queue_unit.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Owns the fetch PC, issues in-order word fetches to a variable-latency
//   instruction memory and buffers the returned words, each tagged with its
//   PC, in a QDEPTH-entry queue that feeds decode through a valid/ready
//   handshake. A redirect flushes the queue and discards every response that
//   is still in flight at that moment.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   redirect_valid/_pc   redirect request from the branch/NPC logic
//   im_req/im_addr       fetch request (always accepted by the IM)
//   im_rvalid/im_rdata   in-order fetch responses, latency >= 1
//   out_valid/out_ready  head-of-queue handshake towards decode
//   out_instr/out_pc*    head entry and its PC, PC+4, PC+8
//   occupancy            number of queued entries
module fetch_queue_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned QDEPTH   = 4,
  localparam int unsigned CW      = $clog2(QDEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          im_req,
  output logic [31:0]   im_addr,
  input  logic          im_rvalid,
  input  logic [31:0]   im_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_pc4,
  output logic [31:0]   out_pc8,
  output logic [CW-1:0] occupancy
);

  localparam int unsigned PW      = $clog2(QDEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(QDEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW:0]   inflight;
  logic          enq, deq;

  logic [31:0]   instr_mem [QDEPTH];
  logic [31:0]   pc_mem    [QDEPTH];

  // Queued entries plus requests in flight never exceed QDEPTH, so every
  // response always has a free slot waiting for it.
  assign inflight  = {1'b0, count_q} + {1'b0, outst_q};
  assign im_req    = !reset && !redirect_valid && (inflight < DEPTH_W);
  assign im_addr   = fetch_pc_q;

  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? instr_mem[head_q] : '0;
  assign out_pc    = out_valid ? pc_mem[head_q] : '0;
  assign out_pc4   = out_valid ? pc_mem[head_q] + 32'd4 : '0;
  assign out_pc8   = out_valid ? pc_mem[head_q] + 32'd8 : '0;
  assign occupancy = count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    enq        = 1'b0;
    deq        = 1'b0;

    if (im_req) fetch_pc_d = fetch_pc_q + 32'd4;

    // Responses are counted even in a redirect cycle.
    case ({im_req, im_rvalid})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      // The in-flight count already includes responses earmarked for
      // dropping, so everything still in flight after this cycle is stale.
      if (im_rvalid && (outst_q != '0)) drop_d = outst_q - CW'(1);
      else                              drop_d = outst_q;
    end else begin
      if (im_rvalid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          enq       = 1'b1;
          resp_pc_d = resp_pc_q + 32'd4;
          tail_d    = tail_q + PW'(1);
        end
      end
      deq = out_valid && out_ready;
      if (deq) head_d = head_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Queue storage needs no reset: out_valid masks any stale contents.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[tail_q] <= im_rdata;
      pc_mem[tail_q]    <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;
  localparam int          QDEPTH   = 4;
  localparam int          CW       = $clog2(QDEPTH) + 1;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          im_req;
  logic [31:0]   im_addr;
  logic          im_rvalid;
  logic [31:0]   im_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr, out_pc, out_pc4, out_pc8;
  logic [CW-1:0] occupancy;

  fetch_queue_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .im_req(im_req), .im_addr(im_addr),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc4(out_pc4), .out_pc8(out_pc8),
    .occupancy(occupancy)
  );

  // Reference model: requests in flight (with a stale flag set by any later
  // redirect) and the list of instructions decode should see.
  typedef struct { logic [31:0] addr; bit stale; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        pend[$];
  ent_t        mq[$];
  logic [31:0] m_fetch_pc;
  int          cyc, last_due, lat_lo, lat_hi;
  int          n_cmp, n_bad;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  function automatic bit model_req();
    return !redirect_valid && ((mq.size() + pend.size()) < QDEPTH);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mq.delete();
    m_fetch_pc = RESET_PC;
    last_due   = cyc;
  endtask

  // Called at posedge+1: apply this cycle's inputs and let outputs settle.
  task automatic drive(input bit rv, input logic [31:0] rpc, input bit rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      im_rvalid = 1'b1;
      im_rdata  = instr_of(pend[0].addr);
    end else begin
      im_rvalid = 1'b0;
      im_rdata  = $urandom();
    end
    #1;
  endtask

  task automatic check_model();
    bit req;
    req = model_req();
    chk("im_req", im_req, req);
    if (req) chk("im_addr", im_addr, m_fetch_pc);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("occupancy", occupancy, mq.size());
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_pc4", out_pc4, mq[0].pc + 32'd4);
      chk("out_pc8", out_pc8, mq[0].pc + 32'd8);
      chk("out_instr", out_instr, mq[0].instr);
    end
  endtask

  // Apply the clock edge to the model, then move to the next posedge+1.
  task automatic advance();
    bit   req, push;
    ent_t n;
    req_t e;
    int   d;
    req  = model_req();
    push = 1'b0;
    if (im_rvalid) begin
      e = pend.pop_front();
      if (!redirect_valid && !e.stale) begin
        n.pc    = e.addr;
        n.instr = instr_of(e.addr);
        push    = 1'b1;
      end
    end
    if (redirect_valid) begin
      mq.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      m_fetch_pc = redirect_pc;
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (push) mq.push_back(n);
      if (req) begin
        d = cyc + $urandom_range(lat_hi, lat_lo);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        pend.push_back('{addr: m_fetch_pc, stale: 1'b0, due: d});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
    drive(rv, rpc, rdy);
    check_model();
    advance();
  endtask

  // Asynchronous reset pulse from the current (mid-cycle) time through the
  // next rising edge; outputs must clear before any edge arrives.
  task automatic pulse_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    im_rvalid      = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_occupancy", occupancy, '0);
    chk("rst_im_req", im_req, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
    last_due = cyc;
  endtask

  // Run with out_ready high until the first entry appears; it must be
  // exp_first and every entry must stay within the 4 KB region given.
  task automatic watch(input string nm, input logic [31:0] exp_first,
                       input logic [19:0] region, input int ncyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      check_model();
      if (out_valid === 1'b1) begin
        if (!seen) chk({nm, "_first_pc"}, out_pc, exp_first);
        seen = 1'b1;
        chk({nm, "_region"}, {12'h0, out_pc[31:12]}, {12'h0, region});
      end
      advance();
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no out_valid within %0d cycles, required an entry", nm, ncyc);
    end
  endtask

  initial begin
    int          nreq;
    bit          hit;
    bit          rv, rdy;
    int          rdy_pct;
    logic [31:0] rpc, r;

    n_cmp = 0; n_bad = 0; cyc = 0;
    lat_lo = 1; lat_hi = 1;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b0; im_rvalid = 1'b0; im_rdata = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_occupancy", occupancy, '0);
    chk("reset_im_req", im_req, 1'b0);
    chk("reset_out_pc", out_pc, '0);
    chk("reset_out_instr", out_instr, '0);
    chk("reset_out_pc8", out_pc8, '0);
    reset = 1'b0;
    model_reset();

    // Latency 1, decode always ready.
    drive(1'b0, 32'h0, 1'b1); check_model();
    chk("A_addr0", im_addr, 32'h0000_3000); advance();
    drive(1'b0, 32'h0, 1'b1); check_model();
    chk("A_addr1", im_addr, 32'h0000_3004); advance();
    drive(1'b0, 32'h0, 1'b1); check_model();
    chk("A_valid", out_valid, 1'b1);
    chk("A_pc", out_pc, 32'h0000_3000);
    chk("A_pc4", out_pc4, 32'h0000_3004);
    chk("A_pc8", out_pc8, 32'h0000_3008);
    chk("A_addr2", im_addr, 32'h0000_3008);
    advance();
    drive(1'b0, 32'h0, 1'b1); check_model();
    chk("A_pc_next", out_pc, 32'h0000_3004); advance();
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1);

    // Decode stalled, latency 2: the queue fills and fetch stops.
    #3; pulse_reset();
    lat_lo = 2; lat_hi = 2;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0, 1'b0); check_model();
      if (im_req === 1'b1) nreq++;
      advance();
    end
    chk("B_req_count", nreq, 4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1); check_model();
      if (i == 0) begin
        chk("B_full_occ", occupancy, 4);
        chk("B_full_noreq", im_req, 1'b0);
      end
      if (i == 1) chk("B_req_resume", im_req, 1'b1);
      chk("B_drain_pc", out_pc, 32'h0000_3000 + 32'(4 * i));
      advance();
    end

    // Redirect with two requests outstanding, latency 3.
    #3; pulse_reset();
    lat_lo = 3; lat_hi = 3;
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_4000, 1'b1);
    drive(1'b0, 32'h0, 1'b1); check_model();
    chk("C_empty", out_valid, 1'b0);
    chk("C_addr", im_addr, 32'h0000_4000);
    advance();
    watch("C", 32'h0000_4000, 20'h00004, 30);

    // Redirect coinciding with a response and a dequeue, latency 2.
    #3; pulse_reset();
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    drive(1'b1, 32'h0000_6000, 1'b1); check_model();
    chk("D_valid", out_valid, 1'b1);
    chk("D_head", out_pc, 32'h0000_3000);
    advance();
    drive(1'b0, 32'h0, 1'b1); check_model();
    chk("D_flushed", occupancy, '0);
    chk("D_addr", im_addr, 32'h0000_6000);
    advance();
    watch("D", 32'h0000_6000, 20'h00006, 30);

    // Back-to-back redirects.
    #3; pulse_reset();
    lat_lo = 3; lat_hi = 3;
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_4000, 1'b1);
    step(1'b1, 32'h0000_5000, 1'b1);
    watch("E", 32'h0000_5000, 20'h00005, 30);

    // Asynchronous reset while three entries are queued.
    #3; pulse_reset();
    lat_lo = 1; lat_hi = 1;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 32'h0, 1'b0); check_model();
      if (mq.size() == 3) begin
        hit = 1'b1;
        break;
      end
      advance();
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL F_fill_timeout: got no 3-entry queue, required one within 20 cycles");
    end else begin
      chk("F_occ3", occupancy, 3);
      chk("F_valid", out_valid, 1'b1);
      #2; pulse_reset();
      drive(1'b0, 32'h0, 1'b1); check_model();
      chk("F_restart_req", im_req, 1'b1);
      chk("F_restart_addr", im_addr, 32'h0000_3000);
      advance();
    end

    // Randomised traffic against the model.
    rdy_pct = 75;
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) begin
        lat_lo  = $urandom_range(1, 2);
        lat_hi  = lat_lo + $urandom_range(0, 3);
        rdy_pct = $urandom_range(10, 100);
      end
      if ($urandom_range(0, 299) == 0) begin
        #3; pulse_reset();
      end
      rv = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: rpc = 32'h0000_4000 + 32'(4 * $urandom_range(0, 255));
        1: rpc = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
        2: rpc = 32'h0000_0000;
        default: begin
          r = $urandom();
          r[1:0] = 2'b00;
          rpc = r;
        end
      endcase
      rdy = ($urandom_range(1, 100) <= rdy_pct);
      step(rv, rpc, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
